// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Framed serial magnitude comparator. Two operands of WORD_DIGITS digits,
//   each DIGIT_W bits wide, arrive one digit pair per valid beat. Digit order
//   (MSB_FIRST) and signedness (SIGNED) are set by parameters. A one-cycle
//   strobe accompanies each completed word's result. A word cut short by a
//   new in_first marker produces a frame_err pulse instead of a result.
//
// Ports
//   clk          in   clock, posedge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   beat qualifier for a_digit/b_digit/in_first
//   in_first     in   beat is digit 0 of a new word
//   a_digit      in   [DIGIT_W-1:0] current digit of operand A
//   b_digit      in   [DIGIT_W-1:0] current digit of operand B
//   out_valid    out  one-cycle strobe, result flags just updated
//   a_less_b     out  A <  B for the last completed word
//   a_eq_b       out  A == B for the last completed word
//   a_greater_b  out  A >  B for the last completed word
//   frame_err    out  one-cycle pulse, partial word discarded
module serial_word_comparator #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8,
  parameter int MSB_FIRST   = 1,
  parameter int SIGNED      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic [DIGIT_W-1:0] a_digit,
  input  logic [DIGIT_W-1:0] b_digit,
  output logic               out_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               frame_err
);

  localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);

  localparam logic [1:0] ST_EQ = 2'b00;
  localparam logic [1:0] ST_LT = 2'b01;
  localparam logic [1:0] ST_GT = 2'b10;

  // Two's complement ordering maps onto unsigned ordering once the sign bit
  // of the sign-carrying digit is flipped in both operands.
  function automatic logic [DIGIT_W-1:0] sign_bias(input logic [DIGIT_W-1:0] d,
                                                   input logic en);
    logic [DIGIT_W-1:0] r;
    r = d;
    if (en) r[DIGIT_W-1] = ~d[DIGIT_W-1];
    return r;
  endfunction

  logic [CNT_W-1:0]   cnt_p0;
  logic [1:0]         state_p0;
  logic               vld_p1;
  logic               lt_p1;
  logic               eq_p1;
  logic               gt_p1;
  logic               ferr_p1;

  logic [CNT_W-1:0]   idx;
  logic               last_beat;
  logic               sign_beat;
  logic [DIGIT_W-1:0] a_adj;
  logic [DIGIT_W-1:0] b_adj;
  logic               dig_lt;
  logic               dig_gt;
  logic [1:0]         st_prev;
  logic [1:0]         st_next;

  // in_first forces the beat to digit 0 regardless of where the counter is.
  assign idx       = in_first ? '0 : cnt_p0;
  assign last_beat = (idx == LAST_IDX);
  assign sign_beat = (MSB_FIRST != 0) ? (idx == '0) : last_beat;

  assign a_adj  = sign_bias(a_digit, (SIGNED != 0) && sign_beat);
  assign b_adj  = sign_bias(b_digit, (SIGNED != 0) && sign_beat);
  assign dig_lt = (a_adj < b_adj);
  assign dig_gt = (a_adj > b_adj);

  // Digit 0 starts from equal so a stale or aborted word never leaks in.
  assign st_prev = (idx == '0) ? ST_EQ : state_p0;

  always_comb begin
    st_next = st_prev;
    if (MSB_FIRST != 0) begin
      // First differing digit from the top decides; later digits cannot override.
      if (st_prev == ST_EQ) begin
        if (dig_lt)      st_next = ST_LT;
        else if (dig_gt) st_next = ST_GT;
      end
    end else begin
      // Later digits are more significant, so any difference overwrites.
      if (dig_lt)      st_next = ST_LT;
      else if (dig_gt) st_next = ST_GT;
    end
  end

  // ---- stage p0 -> p1: running state update and result registration ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0   <= '0;
      state_p0 <= ST_EQ;
      vld_p1   <= 1'b0;
      ferr_p1  <= 1'b0;
      lt_p1    <= 1'b0;
      eq_p1    <= 1'b1;
      gt_p1    <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
      if (in_valid) begin
        state_p0 <= st_next;
        cnt_p0   <= last_beat ? '0 : idx + CNT_W'(1);
        ferr_p1  <= in_first && (cnt_p0 != '0);
        if (last_beat) begin
          vld_p1 <= 1'b1;
          lt_p1  <= (st_next == ST_LT);
          eq_p1  <= (st_next == ST_EQ);
          gt_p1  <= (st_next == ST_GT);
        end
      end
    end
  end

  assign out_valid   = vld_p1;
  assign a_less_b    = lt_p1;
  assign a_eq_b      = eq_p1;
  assign a_greater_b = gt_p1;
  assign frame_err   = ferr_p1;

endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator
//   Directed bench for serial_word_comparator. Five instances share one
//   stimulus bus; each directed step checks the instance it targets.
//   Observed/expected vectors are packed {frame_err, out_valid, lt, eq, gt}.
//   Instances:
//     0: DIGIT_W=1 WORD_DIGITS=4 MSB_FIRST=1 SIGNED=0
//     1: DIGIT_W=1 WORD_DIGITS=4 MSB_FIRST=0 SIGNED=0
//     2: DIGIT_W=2 WORD_DIGITS=2 MSB_FIRST=1 SIGNED=1
//     3: DIGIT_W=2 WORD_DIGITS=2 MSB_FIRST=1 SIGNED=0
//     4: DIGIT_W=2 WORD_DIGITS=1 MSB_FIRST=1 SIGNED=0
module tb_serial_word_comparator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_first;
  logic [1:0] a_d;
  logic [1:0] b_d;

  logic [4:0] ov, lt, eq, gt, fe;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_word_comparator #(.DIGIT_W(1), .WORD_DIGITS(4), .MSB_FIRST(1), .SIGNED(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .a_digit(a_d[0:0]), .b_digit(b_d[0:0]),
    .out_valid(ov[0]), .a_less_b(lt[0]), .a_eq_b(eq[0]), .a_greater_b(gt[0]),
    .frame_err(fe[0]));

  serial_word_comparator #(.DIGIT_W(1), .WORD_DIGITS(4), .MSB_FIRST(0), .SIGNED(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .a_digit(a_d[0:0]), .b_digit(b_d[0:0]),
    .out_valid(ov[1]), .a_less_b(lt[1]), .a_eq_b(eq[1]), .a_greater_b(gt[1]),
    .frame_err(fe[1]));

  serial_word_comparator #(.DIGIT_W(2), .WORD_DIGITS(2), .MSB_FIRST(1), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .a_digit(a_d), .b_digit(b_d),
    .out_valid(ov[2]), .a_less_b(lt[2]), .a_eq_b(eq[2]), .a_greater_b(gt[2]),
    .frame_err(fe[2]));

  serial_word_comparator #(.DIGIT_W(2), .WORD_DIGITS(2), .MSB_FIRST(1), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .a_digit(a_d), .b_digit(b_d),
    .out_valid(ov[3]), .a_less_b(lt[3]), .a_eq_b(eq[3]), .a_greater_b(gt[3]),
    .frame_err(fe[3]));

  serial_word_comparator #(.DIGIT_W(2), .WORD_DIGITS(1), .MSB_FIRST(1), .SIGNED(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .a_digit(a_d), .b_digit(b_d),
    .out_valid(ov[4]), .a_less_b(lt[4]), .a_eq_b(eq[4]), .a_greater_b(gt[4]),
    .frame_err(fe[4]));

  function automatic logic [4:0] st(input int i);
    return {fe[i], ov[i], lt[i], eq[i], gt[i]};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={fe,ov,lt,eq,gt}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the sampling edge.
  task automatic step(input logic v, input logic f, input logic [1:0] a, input logic [1:0] b);
    in_valid = v;
    in_first = f;
    a_d      = a;
    b_d      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_first = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    a_d      = 2'd0;
    b_d      = 2'd0;

    // Reset state
    do_reset();
    chk("reset_msb", st(0), 5'b00010);
    chk("reset_lsb", st(1), 5'b00010);
    chk("reset_sgn", st(2), 5'b00010);

    // Test 1: A=1010 B=1001 MSB first
    step(1'b1, 1'b1, 2'd1, 2'd1);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd1, 2'd0);
    chk("t1_no_early_strobe", st(0), 5'b00010);
    step(1'b1, 1'b0, 2'd0, 2'd1);
    chk("t1_gt_strobe", st(0), 5'b01001);
    idle();
    chk("t1_strobe_one_cycle", st(0), 5'b00001);

    // Test 4: test 1 with 3 stall cycles between beats
    do_reset();
    step(1'b1, 1'b1, 2'd1, 2'd1);
    repeat (3) idle();
    step(1'b1, 1'b0, 2'd0, 2'd0);
    repeat (3) idle();
    step(1'b1, 1'b0, 2'd1, 2'd0);
    repeat (3) idle();
    chk("t4_stall_no_strobe", st(0), 5'b00010);
    step(1'b1, 1'b0, 2'd0, 2'd1);
    chk("t4_gt_strobe", st(0), 5'b01001);
    idle();
    chk("t4_hold", st(0), 5'b00001);

    // Test 2: LSB first, A=1010 B=1001 then A=B=0110 back to back
    do_reset();
    step(1'b1, 1'b1, 2'd0, 2'd1);
    step(1'b1, 1'b0, 2'd1, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd1, 2'd1);
    chk("t2_lsb_gt", st(1), 5'b01001);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    chk("t2_flags_held", st(1), 5'b00001);
    step(1'b1, 1'b0, 2'd1, 2'd1);
    step(1'b1, 1'b0, 2'd1, 2'd1);
    chk("t2_no_strobe_mid", st(1), 5'b00001);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    chk("t2_lsb_eq_b2b", st(1), 5'b01010);
    idle();

    // Test 3: A=4'hF, B=4'h1, two 2-bit digits; also WORD_DIGITS=1 instance
    do_reset();
    step(1'b1, 1'b1, 2'd3, 2'd0);
    chk("t3_w1_gt", st(4), 5'b01001);
    step(1'b1, 1'b0, 2'd3, 2'd1);
    chk("t3_signed_lt", st(2), 5'b01100);
    chk("t3_unsigned_gt", st(3), 5'b01001);
    chk("t3_w1_gt2", st(4), 5'b01001);
    step(1'b1, 1'b1, 2'd1, 2'd2);
    chk("t3_w1_first_no_ferr", st(4), 5'b01100);
    idle();

    // Test 5: in_first on beat 2 aborts the word; new A=0001 B=0010
    do_reset();
    step(1'b1, 1'b1, 2'd1, 2'd1);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b1, 2'd0, 2'd0);
    chk("t5_frame_err", st(0), 5'b10010);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    chk("t5_ferr_one_cycle", st(0), 5'b00010);
    step(1'b1, 1'b0, 2'd0, 2'd1);
    step(1'b1, 1'b0, 2'd1, 2'd0);
    chk("t5_lt_strobe", st(0), 5'b01100);
    idle();

    // Test 6: reset mid-word after a gt result
    do_reset();
    step(1'b1, 1'b1, 2'd1, 2'd1);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd1, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd1);
    chk("t6_pre_gt", st(0), 5'b01001);
    step(1'b1, 1'b1, 2'd1, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t6_async_reset", st(0), 5'b00010);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk("t6_after_release", st(0), 5'b00010);
    step(1'b1, 1'b1, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'd1);
    step(1'b1, 1'b0, 2'd1, 2'd0);
    chk("t6_fresh_lt", st(0), 5'b01100);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
